fetch_queue: RTL and testbench

- Instruction prefetch buffer between instruction memory and the IF/ID pipeline register of the five-stage CPU.
- Issues sequential fetch requests to a latency-variable instruction memory and buffers returned words with their PC+4.
- Presents one instruction per cycle to the IF stage, honouring the IF/ID hold (load-use stall).
- Flushes on branch/jump redirect and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fq_fifo.sv | 50 +++++
 rtl/fetch_queue.sv | 157 +++++++++++++++
 tb/tb_fetch_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch queue.
// Latency: none; types and constants only.
// Backpressure: none.
package fetch_pkg;

   localparam logic [31:0] INST_BYTES = 32'd4;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
   } fq_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fq_state_t;

endpackage

// File: rtl/fq_fifo.sv
// fq_fifo: DEPTH-entry synchronous FIFO of fetch entries with a one-cycle clear.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module fq_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 push,
   input  fq_entry_t            wr_entry,
   input  logic                 pop,
   output fq_entry_t            head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   fq_entry_t     mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   // pointers and fill level; clear wins over any same-cycle push or pop
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // entry storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= wr_entry;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer feeding IF/ID; optional same-cycle bypass under FETCH_QUEUE_BYPASS_EN.
// Latency: a memory response reaches out_valid one cycle after mem_rvalid (zero cycles when bypassing an empty queue).
// Backpressure: hold stalls the head; issue stops once queued plus in-flight words would reach DEPTH.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'd0
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirect,
   input  logic [31:0]            redirect_pc,
   input  logic                   hold,
   output logic                   out_valid,
   output logic [31:0]            out_inst,
   output logic [31:0]            out_pc4,
   output logic                   mem_req,
   output logic [31:0]            mem_addr,
   input  logic                   mem_gnt,
   input  logic                   mem_rvalid,
   input  logic [31:0]            mem_rdata,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int CW = $clog2(DEPTH) + 1;

   fq_state_t   state;
   fq_state_t   state_nxt;
   logic [31:0] fetch_pc;
   logic [31:0] wr_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] rsp_ext;
   logic [CW-1:0] issue_ext;
   logic [CW-1:0] left_after_rsp;
   logic [CW-1:0] drop_left;
   logic          rsp;
   logic          issue;
   logic          push;
   logic          pop;
   fq_entry_t     head;
   fq_entry_t     wr_entry;
`ifdef FETCH_QUEUE_BYPASS_EN
   logic          bypass;
`endif

   // a response only counts when something is actually in flight
   assign rsp            = mem_rvalid && (outstanding != '0);
   assign issue          = mem_req && mem_gnt;
   assign rsp_ext        = {{(CW-1){1'b0}}, rsp};
   assign issue_ext      = {{(CW-1){1'b0}}, issue};
   assign left_after_rsp = outstanding - rsp_ext;
   assign drop_left      = drop_cnt - rsp_ext;
   assign wr_entry       = '{inst: mem_rdata, pc4: wr_pc + INST_BYTES};

   fq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clear    (redirect),
      .push     (push),
      .wr_entry (wr_entry),
      .pop      (pop),
      .head     (head),
      .count    (count)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // next state: enter DRAIN while stale responses are still owed, leave when the last arrives
   always_comb begin
      state_nxt = state;
      if (redirect) begin
         state_nxt = (left_after_rsp != '0) ? DRAIN : RUN;
      end else if (state == DRAIN && drop_left == '0) begin
         state_nxt = RUN;
      end
   end

   // outputs and queue controls; everything is forced quiet while in reset
   always_comb begin
      mem_req   = 1'b0;
      mem_addr  = '0;
      occupancy = '0;
      out_valid = 1'b0;
      out_inst  = '0;
      out_pc4   = '0;
      push      = 1'b0;
      pop       = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass    = 1'b0;
`endif
      if (!rst) begin
         // credits cover both queued words and words still in flight, so pushes never overflow
         mem_req   = (state == RUN) && !redirect
                     && ((int'(count) + int'(outstanding)) < DEPTH)
                     && (int'(outstanding) < MAX_OUTSTANDING);
         mem_addr  = fetch_pc;
         occupancy = count;
         pop       = (count != '0) && !hold && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
         bypass    = (count == '0) && (state == RUN) && rsp && !redirect;
         // a bypassed word consumed this cycle never needs a slot
         push      = (state == RUN) && rsp && !redirect && !(bypass && !hold);
         out_valid = (count != '0) || bypass;
         if (count != '0) begin
            out_inst = head.inst;
            out_pc4  = head.pc4;
         end else if (bypass) begin
            out_inst = mem_rdata;
            out_pc4  = wr_pc + INST_BYTES;
         end
`else
         push      = (state == RUN) && rsp && !redirect;
         out_valid = (count != '0);
         if (count != '0) begin
            out_inst = head.inst;
            out_pc4  = head.pc4;
         end
`endif
      end
   end

   // fetch/write PCs, in-flight credit count and stale-response counter
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         wr_pc       <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + issue_ext - rsp_ext;
         if (redirect) begin
            // in DRAIN outstanding equals drop_cnt, so this also continues the countdown
            fetch_pc <= redirect_pc;
            wr_pc    <= redirect_pc;
            drop_cnt <= left_after_rsp;
         end else begin
            if (issue)                 fetch_pc <= fetch_pc + INST_BYTES;
            if (state == RUN && rsp)   wr_pc    <= wr_pc + INST_BYTES;
            if (state == DRAIN)        drop_cnt <= drop_left;
         end
      end
   end

   // a response with nothing in flight means the memory broke the request/response protocol
   a_rsp_has_credit: assert property (@(posedge clk) disable iff (rst)
      !(mem_rvalid && outstanding == '0));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized bench for fetch_queue against a queue-level reference model.
// Latency: the model predicts out_valid/occupancy/mem_req each cycle from queued and in-flight words.
// Backpressure: random hold, grant and response throttling, plus directed saturation and redirect cases.
`timescale 1ns/1ps
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          MAXO     = 2;
   localparam logic [31:0] RESET_PC = 32'd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        hold;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc4;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [2:0]  occupancy;

   fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .hold        (hold),
      .out_valid   (out_valid),
      .out_inst    (out_inst),
      .out_pc4     (out_pc4),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .occupancy   (occupancy)
   );

   always #5 clk = ~clk;

   // in-flight request as seen by the memory: address, fetch epoch, earliest response cycle
   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          ready;
   } req_t;

   req_t        pend[$];
   logic [31:0] mq[$];
   int          epoch;
   int          cyc;
   int          n_checks;
   int          n_fail;
   int          n_deliv;
   logic [31:0] fetch_pc;
   int          gnt_pct;
   int          hold_pct;
   int          redir_pct;
   int          lat_min;
   int          lat_max;
   bit          force_redir;
   logic [31:0] force_pc;
   logic        obs_req;
   logic [2:0]  obs_occ;
   logic [31:0] obs_addr;
   logic [31:0] dut_deliv_pc4;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[7:0], a[15:8], ~a[23:16], a[31:24]} ^ 32'h5A5A_1234;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      bit          stale;
      bit          exp_req;
      bit          exp_valid;
      bit          byp;
      bit          fire;
      bit          accepted;
      logic [31:0] exp_pc;
      req_t        r;
      @(negedge clk);
      rst         = 1'b0;
      hold        = ($urandom_range(0, 99) < hold_pct);
      mem_gnt     = ($urandom_range(0, 99) < gnt_pct);
      redirect    = force_redir || ($urandom_range(0, 99) < redir_pct);
      redirect_pc = force_redir ? force_pc : ($urandom & 32'hFFFF_FFFC);
      force_redir = 1'b0;
      mem_rvalid  = (pend.size() > 0) && (pend[0].ready <= cyc)
                    && (lat_max == 0 || $urandom_range(0, 3) != 0);
      mem_rdata   = mem_rvalid ? word_at(pend[0].addr) : $urandom;
      #1;
      stale   = (pend.size() > 0) && (pend[0].epoch != epoch);
      exp_req = !stale && !redirect && (mq.size() + pend.size() < DEPTH) && (pend.size() < MAXO);
      byp     = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp     = mem_rvalid && !stale && !redirect && (mq.size() == 0);
`endif
      exp_valid = (mq.size() != 0) || byp;
      check("mem_req", mem_req, exp_req);
      check("occupancy", occupancy, mq.size());
      check("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
         exp_pc = (mq.size() != 0) ? mq[0] : pend[0].addr;
         check("out_inst", out_inst, word_at(exp_pc));
         check("out_pc4", out_pc4, exp_pc + 32'd4);
      end
      if (mem_req && exp_req) check("mem_addr", mem_addr, fetch_pc);
      obs_req  = mem_req;
      obs_occ  = occupancy;
      obs_addr = mem_addr;

      fire     = mem_req && mem_gnt;
      accepted = 1'b0;
      if (mem_rvalid) begin
         r        = pend.pop_front();
         accepted = (r.epoch == epoch) && !redirect;
      end
      if (fire) begin
         pend.push_back('{addr: fetch_pc, epoch: epoch, ready: cyc + 1 + $urandom_range(lat_min, lat_max)});
         fetch_pc += 32'd4;
      end
      if (redirect) begin
         mq.delete();
         epoch++;
         fetch_pc = redirect_pc;
      end else begin
         if (exp_valid && !hold) begin
            n_deliv++;
            dut_deliv_pc4 = out_pc4;
         end
         if (mq.size() != 0 && !hold) void'(mq.pop_front());
         if (accepted && !(byp && !hold)) mq.push_back(r.addr);
      end
      cyc++;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst        = 1'b1;
         redirect   = 1'b0;
         mem_rvalid = 1'b0;
         mem_gnt    = 1'($urandom_range(0, 1));
         hold       = 1'($urandom_range(0, 1));
         #1;
         check("rst_out_valid", out_valid, 0);
         check("rst_mem_req", mem_req, 0);
         check("rst_mem_addr", mem_addr, 0);
         check("rst_occupancy", occupancy, 0);
         check("rst_out_inst", out_inst, 0);
         check("rst_out_pc4", out_pc4, 0);
         cyc++;
      end
      pend.delete();
      mq.delete();
      epoch++;
      fetch_pc = RESET_PC;
   endtask

   initial begin
      int snap;
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; hold = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      force_redir = 1'b0; force_pc = '0; epoch = 0; cyc = 0;
      n_checks = 0; n_fail = 0; n_deliv = 0; fetch_pc = RESET_PC;
      gnt_pct = 100; hold_pct = 0; redir_pct = 0; lat_min = 0; lat_max = 0;
      dut_deliv_pc4 = '0;

      do_reset(3);

      // back-to-back stream with single-cycle memory
      step();
      check("first_req", obs_req, 1);
      check("first_addr", obs_addr, RESET_PC);
      repeat (20) step();
      check("stream_progress", n_deliv >= 15, 1);

      // hold saturates the queue and throttles issue
      hold_pct = 100;
      repeat (10) step();
      check("hold_occ_sat", obs_occ, DEPTH);
      check("hold_req_low", obs_req, 0);
      hold_pct = 0;
      repeat (10) step();

      // redirect to 0x40 with two requests in flight
      lat_min = 3; lat_max = 3;
      snap = 0;
      while (pend.size() != 2 && snap < 20) begin
         step();
         snap++;
      end
      check("redir_two_inflight", pend.size(), 2);
      force_redir = 1'b1; force_pc = 32'h40;
      step();
      step();
      check("redir_occ_empty", obs_occ, 0);
      check("redir_req_drain", obs_req, 0);
      lat_min = 0; lat_max = 0;
      snap = n_deliv;
      for (int i = 0; i < 40 && n_deliv == snap; i++) step();
      check("redir_first_pc4", dut_deliv_pc4, 32'h44);
      repeat (10) step();

      // no grants: address must hold still
      gnt_pct = 0;
      repeat (5) step();
      check("gnt0_req_high", obs_req, 1);
      check("gnt0_addr_stable", obs_addr, fetch_pc);
      gnt_pct = 100;

      // reset mid-stream
      repeat (7) step();
      do_reset(2);
      step();
      check("post_rst_req", obs_req, 1);
      check("post_rst_addr", obs_addr, RESET_PC);

      // randomized traffic with redirects, stalls and variable latency
      gnt_pct = 70; hold_pct = 30; redir_pct = 4; lat_min = 0; lat_max = 3;
      for (int i = 0; i < 4000; i++) begin
         if (i == 1500) begin
            force_redir = 1'b1;
            force_pc    = 32'hFFFF_FFF8;
         end
         if (i == 2500) do_reset(1);
         step();
      end
      check("random_progress", n_deliv > 1000, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
